fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage at the head of the 5-stage pipeline. It owns the PC and drives the instruction-memory address. It captures the fetched word into the IF/ID pipeline register that feeds the ID stage. It handles stall, flush, taken-branch redirect and HLT detection, and stops fetching on halt.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
ADDR_W, 16, PC / instruction-memory address width (word addressed).

Ports:
clk  in  1  global clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hazard unit: hold PC and IF/ID.
flush  in  1  hazard unit: squash IF/ID contents.
br_taken  in  1  taken branch/jump resolved downstream.
br_target  in  ADDR_W  redirect address, valid when br_taken=1.
im_instr  in  16  instruction word from instruction memory (combinational read of im_addr).
im_addr  out  ADDR_W  instruction-memory address; always equals the PC.
im_rd_en  out  1  instruction-memory read enable.
instr_IF_ID  out  16  IF/ID instruction register.
pc_plus1_IF_ID  out  ADDR_W  IF/ID copy of fetch PC+1.
valid_IF_ID  out  1  IF/ID holds a real instruction.
halted  out  1  fetch has stopped on HLT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - pc = RESET_PC.
  - instr_IF_ID = NOP_INSTR (16'h0000).
  - pc_plus1_IF_ID = 0.
  - valid_IF_ID = 0.
  - state = RUN, so halted = 0.
- Reset mid-operation clears everything immediately, regardless of stall, branch or state.
- Combinational outputs:
  - im_addr = pc.
  - im_rd_en = (state==RUN) & ~stall & ~br_taken.
  - halted = (state==HALTED).
- Latency: a word at im_addr in cycle N appears on instr_IF_ID after edge N+1.
- State machine with two states, RUN and HALTED. Per rising edge, the first matching rule applies.
- Rule 1, br_taken=1 (any state, overrides stall and flush):
  - pc <= br_target.
  - IF/ID <= NOP_INSTR, valid 0, pc_plus1 0.
  - state <= RUN. This exits HALTED, so a halt fetched in a branch shadow is squashed.
- Rule 2, flush=1:
  - IF/ID <= NOP, valid 0.
  - pc held, so the same address is refetched next cycle.
  - state unchanged.
- Rule 3, stall=1: pc, IF/ID and state all held.
- Rule 4, RUN with none of the above:
  - IF/ID <= im_instr, valid 1, pc_plus1 <= pc+1.
  - pc <= pc+1, modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000, no flag).
  - If im_instr[15:12]==HLT_OP (4'hF): state <= HALTED and pc is held at the HLT address instead of incrementing. The HLT itself still enters IF/ID with valid 1.
- Rule 5, HALTED with none of the above: IF/ID <= NOP, valid 0; pc held.
- Only br_taken or rst_n leaves HALTED.
- Simultaneous stall+flush: flush wins (rule 2).
- im_instr is ignored whenever im_rd_en=0.

Decomposition:
- Shared package fetch_pkg holds:
  - NOP_INSTR = 16'h0000.
  - HLT_OP = 4'hF.
  - the state encoding, RUN = 1'b0, HALTED = 1'b1.
  - ADDR_W default.
- ID reuses NOP_INSTR and HLT_OP from this package.
- One sub-module, if_id_reg: the IF/ID register (16-bit instr, ADDR_W pc_plus1, 1-bit valid). It is asynchronously reset to the NOP values and has enable (~stall) and synchronous clear (flush|br_taken|halted-bubble) inputs.
- The PC register and the next-state logic stay in fetch_stage.

Test Plan:
1. Reset/straight-line: release rst_n with IM[0..3]=16'h1234,16'h2345,16'h3456,16'h4567. Expect:
   - im_addr steps 0,1,2,3.
   - instr_IF_ID = 16'h1234 one edge after addr 0, then 16'h2345, and so on.
   - valid_IF_ID=1 and pc_plus1_IF_ID=1,2,3,4.
2. Stall: assert stall 2 cycles while pc=2. Expect:
   - im_addr stays 2 and im_rd_en=0.
   - instr_IF_ID stays 16'h2345.
   - On release, fetch resumes with 16'h3456.
3. Branch over stall+flush: at pc=5, assert br_taken=1, br_target=16'h0040 together with stall=1 and flush=1. Expect:
   - next im_addr=16'h0040.
   - instr_IF_ID=16'h0000 with valid_IF_ID=0.
   - the following cycle captures IM[0x40] with valid 1.
4. Halt: IM[6]=16'hF000. Expect:
   - 16'hF000 enters IF/ID with valid 1 and halted=1 after that edge.
   - im_addr stays 6 and im_rd_en=0.
   - subsequent IF/ID valid=0 for 10 cycles.
   - then br_taken with br_target=16'h0010 gives halted=0 and fetch resumes from 0x10.
5. Wrap: br_target=16'hFFFF, then run 2 cycles. Expect:
   - im_addr sequence FFFF, 0000.
   - pc_plus1_IF_ID=16'h0000 for the FFFF fetch.
6. Async reset mid-run: drop rst_n between edges while pc=0x23 and HALTED. Expect the outputs to reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants: NOP encoding, HLT opcode and the fetch state encoding.
package fetch_pkg;

  localparam int ADDR_W_DEF = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]  HLT_OP    = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[15:12] == HLT_OP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; clear takes priority over enable so a squash is never lost to a stall.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [15:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_plus1_in,
  output logic [15:0]       instr_out,
  output logic [ADDR_W-1:0] pc_plus1_out,
  output logic              valid_out
);

  logic [15:0]       instr_d, instr_q;
  logic [ADDR_W-1:0] pc_plus1_d, pc_plus1_q;
  logic              valid_d, valid_q;

  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    if (clr) begin
      instr_d    = NOP_INSTR;
      pc_plus1_d = '0;
      valid_d    = 1'b0;
    end else if (en) begin
      instr_d    = instr_in;
      pc_plus1_d = pc_plus1_in;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus1_out = pc_plus1_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, feeds the IF/ID register, handles stall/flush/redirect/halt.
//   state  | meaning
//   RUN    | fetching sequentially from pc
//   HALTED | HLT fetched; pc frozen at HLT address, bubbles into IF/ID
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [15:0]       im_instr,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_rd_en,
  output logic [15:0]       instr_IF_ID,
  output logic [ADDR_W-1:0] pc_plus1_IF_ID,
  output logic              valid_IF_ID,
  output logic              halted
);

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] pc_plus1;
  logic              reg_en, reg_clr;

  assign pc_plus1 = pc_q + ADDR_W'(1);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (br_taken) begin
      pc_d    = br_target;
      state_d = RUN;
    end else if (flush || stall) begin
      // flush keeps pc so the squashed address is refetched
    end else if (state_q == RUN) begin
      if (is_hlt(im_instr)) state_d = HALTED;
      else                  pc_d    = pc_plus1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign im_addr  = pc_q;
  assign halted   = (state_q == HALTED);
  assign im_rd_en = (state_q == RUN) & ~stall & ~br_taken;
  assign reg_en   = ~stall;
  assign reg_clr  = br_taken | flush | (halted & ~stall);

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (reg_en),
    .clr          (reg_clr),
    .instr_in     (im_instr),
    .pc_plus1_in  (pc_plus1),
    .instr_out    (instr_IF_ID),
    .pc_plus1_out (pc_plus1_IF_ID),
    .valid_out    (valid_IF_ID)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a combinational instruction-memory array.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, br_taken;
  logic [15:0] br_target;
  logic [15:0] im_instr;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] instr_IF_ID;
  logic [15:0] pc_plus1_IF_ID;
  logic        valid_IF_ID;
  logic        halted;

  logic [15:0] mem [0:65535];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign im_instr = mem[im_addr];

  fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .im_instr       (im_instr),
    .im_addr        (im_addr),
    .im_rd_en       (im_rd_en),
    .instr_IF_ID    (instr_IF_ID),
    .pc_plus1_IF_ID (pc_plus1_IF_ID),
    .valid_IF_ID    (valid_IF_ID),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic [15:0] pp1,
                          input logic v);
    chk({tag, ".instr"}, 32'(instr_IF_ID), 32'(ins));
    chk({tag, ".pp1"},   32'(pc_plus1_IF_ID), 32'(pp1));
    chk({tag, ".valid"}, 32'(valid_IF_ID), 32'(v));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h5000 | (16'(i) & 16'h0FFF);
    mem[0]      = 16'h1234;
    mem[1]      = 16'h2345;
    mem[2]      = 16'h3456;
    mem[3]      = 16'h4567;
    mem[6]      = 16'hF000;
    mem[16'h23] = 16'hF123;

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    #2;
    chk("rst.addr", 32'(im_addr), 32'h0);
    chk("rst.halted", 32'(halted), 32'h0);
    chk_ifid("rst", 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("run.rd_en", 32'(im_rd_en), 32'h1);

    // straight-line fetch
    tick(); chk_ifid("e1", 16'h1234, 16'h0001, 1'b1); chk("e1.addr", 32'(im_addr), 32'h1);
    tick(); chk_ifid("e2", 16'h2345, 16'h0002, 1'b1); chk("e2.addr", 32'(im_addr), 32'h2);

    // stall two cycles at pc=2
    stall = 1'b1; #1;
    chk("stall.rd_en", 32'(im_rd_en), 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_ifid("stall", 16'h2345, 16'h0002, 1'b1);
      chk("stall.addr", 32'(im_addr), 32'h2);
    end
    stall = 1'b0; #1;
    chk("unstall.rd_en", 32'(im_rd_en), 32'h1);
    tick(); chk_ifid("e5", 16'h3456, 16'h0003, 1'b1); chk("e5.addr", 32'(im_addr), 32'h3);
    tick(); chk_ifid("e6", 16'h4567, 16'h0004, 1'b1); chk("e6.addr", 32'(im_addr), 32'h4);
    tick(); chk_ifid("e7", 16'h5004, 16'h0005, 1'b1); chk("e7.addr", 32'(im_addr), 32'h5);

    // branch overrides stall and flush
    br_taken = 1'b1; br_target = 16'h0040; stall = 1'b1; flush = 1'b1; #1;
    chk("br.rd_en", 32'(im_rd_en), 32'h0);
    tick(); chk_ifid("br", 16'h0000, 16'h0000, 1'b0); chk("br.addr", 32'(im_addr), 32'h40);
    br_taken = 1'b0; stall = 1'b0; flush = 1'b0;
    tick(); chk_ifid("br+1", 16'h5040, 16'h0041, 1'b1); chk("br+1.addr", 32'(im_addr), 32'h41);

    // halt at address 6
    br_taken = 1'b1; br_target = 16'h0006;
    tick(); chk("toh.addr", 32'(im_addr), 32'h6); chk("toh.valid", 32'(valid_IF_ID), 32'h0);
    br_taken = 1'b0;
    tick();
    chk_ifid("hlt", 16'hF000, 16'h0007, 1'b1);
    chk("hlt.halted", 32'(halted), 32'h1);
    chk("hlt.addr", 32'(im_addr), 32'h6);
    chk("hlt.rd_en", 32'(im_rd_en), 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("halted.valid", 32'(valid_IF_ID), 32'h0);
      chk("halted.instr", 32'(instr_IF_ID), 32'h0);
      chk("halted.addr", 32'(im_addr), 32'h6);
      chk("halted.halted", 32'(halted), 32'h1);
    end
    br_taken = 1'b1; br_target = 16'h0010;
    tick(); chk("unh.halted", 32'(halted), 32'h0); chk("unh.addr", 32'(im_addr), 32'h10);
    br_taken = 1'b0;
    tick(); chk_ifid("unh+1", 16'h5010, 16'h0011, 1'b1); chk("unh+1.addr", 32'(im_addr), 32'h11);

    // flush alone refetches the same address
    flush = 1'b1;
    tick(); chk_ifid("fl", 16'h0000, 16'h0000, 1'b0); chk("fl.addr", 32'(im_addr), 32'h11);
    flush = 1'b0;
    tick(); chk_ifid("fl+1", 16'h5011, 16'h0012, 1'b1); chk("fl+1.addr", 32'(im_addr), 32'h12);

    // stall+flush: flush wins
    stall = 1'b1; flush = 1'b1;
    tick(); chk_ifid("sf", 16'h0000, 16'h0000, 1'b0); chk("sf.addr", 32'(im_addr), 32'h12);
    stall = 1'b0; flush = 1'b0;

    // PC wrap
    br_taken = 1'b1; br_target = 16'hFFFF;
    tick(); chk("wr.addr", 32'(im_addr), 32'hFFFF);
    br_taken = 1'b0;
    tick(); chk_ifid("wr1", 16'h5FFF, 16'h0000, 1'b1); chk("wr1.addr", 32'(im_addr), 32'h0);
    tick(); chk_ifid("wr2", 16'h1234, 16'h0001, 1'b1); chk("wr2.addr", 32'(im_addr), 32'h1);

    // async reset while HALTED at 0x23
    br_taken = 1'b1; br_target = 16'h0023;
    tick();
    br_taken = 1'b0;
    tick();
    chk_ifid("h23", 16'hF123, 16'h0024, 1'b1);
    chk("h23.halted", 32'(halted), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.addr", 32'(im_addr), 32'h0);
    chk("arst.halted", 32'(halted), 32'h0);
    chk_ifid("arst", 16'h0000, 16'h0000, 1'b0);
    chk("arst.rd_en", 32'(im_rd_en), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
